// File: rtl/calc_io_pkg.sv
// Shared constants and helpers for the calculator I/O responder.
// Register offsets are word offsets taken from address bits [3:2].
package calc_io_pkg;

  localparam logic [1:0] KEY_DATA   = 2'd0;
  localparam logic [1:0] KEY_STATUS = 2'd1;
  localparam logic [1:0] DISP_VAL   = 2'd2;
  localparam logic [1:0] CTRL       = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CtrlDispEnBit = 0;
  localparam int unsigned CtrlOvfClrBit = 1;

  // KEY_STATUS read layout
  typedef struct packed {
    logic [23:0] rsvd;
    logic [3:0]  count;
    logic        zero;
    logic        ovf;
    logic        full;
    logic        nempty;
  } key_status_t;

  // Hex nibble to 7-segment pattern {g..a}, active-low
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] lit;
    lit = 7'h00;
    unique case (nib)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      4'hF: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/calc_io_responder_if.sv
// Data-memory bus as seen by the I/O responder. The processor side is the
// master; the responder drives back read data and its window select.
interface calc_io_responder_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic        RE;
  logic [31:0] RD;
  logic        sel;

  modport master (output A, WD, WE, RE, input RD, sel);
  modport slave  (input A, WD, WE, RE, output RD, sel);
endinterface

// File: rtl/key_fifo.sv
// Small synchronous FIFO for keypad codes. A push while full is dropped
// unless a pop happens in the same cycle, in which case both complete.
// A pop while empty is ignored.
module key_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot the push lands in
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while not counted, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/calc_io_responder.sv
// Memory-mapped keypad/display responder for the single-cycle calculator core.
// Reads are combinational from pre-edge state; pops and writes land at the edge.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
module calc_io_responder
  import calc_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'h0000_0400,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SCAN_DIV   = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  calc_io_responder_if.slave        bus,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  output logic [3:0]                an,
  output logic [6:0]                seg
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

  // Bus decode
  logic       sel;
  logic [1:0] reg_idx;
  logic       pop_req, wr_disp, wr_ctrl, ovf_clr;

  // FIFO interface
  logic [3:0]      fifo_dout;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic [4:0]      count_ext;

  // Registers
  logic             ovf_q, ovf_d;
  logic             disp_en_q, disp_en_d;
  logic [15:0]      disp_val_q, disp_val_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             scan_wrap;
  logic [3:0]       nib;
  logic             blank;

  assign sel     = (bus.A >= IO_BASE) && (bus.A <= (IO_BASE + 32'd15));
  assign reg_idx = bus.A[3:2];
  assign bus.sel = sel;

  assign pop_req = bus.RE & sel & (reg_idx == KEY_DATA) & ~fifo_empty;
  assign wr_disp = bus.WE & sel & (reg_idx == DISP_VAL);
  assign wr_ctrl = bus.WE & sel & (reg_idx == CTRL);
  assign ovf_clr = wr_ctrl & bus.WD[CtrlOvfClrBit];

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_key_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (key_valid),
    .pop   (pop_req),
    .din   (key_code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Depth 16 reports 16 as 0 in the 4-bit field; full flags it
  assign count_ext = 5'(fifo_count);

  logic unused_bits;
  assign unused_bits = ^{bus.WD[31:16], count_ext[4]};

  // Read mux, zero outside the window
  always_comb begin
    key_status_t st;
    st        = '0;
    st.count  = count_ext[3:0];
    st.ovf    = ovf_q;
    st.full   = fifo_full;
    st.nempty = ~fifo_empty;
    bus.RD    = 32'h0;
    if (sel) begin
      unique case (reg_idx)
        KEY_DATA:   bus.RD = {28'h0, fifo_empty ? 4'h0 : fifo_dout};
        KEY_STATUS: bus.RD = st;
        DISP_VAL:   bus.RD = {16'h0, disp_val_q};
        CTRL:       bus.RD = {31'h0, disp_en_q};
      endcase
    end
  end

  // Software-visible register next-state; an overflow in the clearing cycle wins
  always_comb begin
    disp_val_d = disp_val_q;
    disp_en_d  = disp_en_q;
    ovf_d      = ovf_q;
    if (wr_disp) disp_val_d = bus.WD[15:0];
    if (wr_ctrl) disp_en_d = bus.WD[CtrlDispEnBit];
    if (ovf_clr) ovf_d = 1'b0;
    if (key_valid & fifo_full & ~pop_req) ovf_d = 1'b1;
  end

  // Scan timing; the shadow value only changes at slot boundaries to avoid tearing
  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanMax);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
    idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
    shadow_d   = scan_wrap ? disp_val_d : shadow_q;
  end

  // Digit drive for the current index, registered one cycle later
  always_comb begin
    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_q != 2'd0) && ((shadow_q >> {idx_q, 2'b00}) == 16'h0);
`endif
    an_d  = disp_en_q ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d = (disp_en_q && !blank) ? hex_to_seg(nib) : 7'h7F;
  end

  // All state; reset overrides any concurrent bus or key activity
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q      <= 1'b0;
      disp_en_q  <= 1'b0;
      disp_val_q <= 16'h0;
      shadow_q   <= 16'h0;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
    end else begin
      ovf_q      <= ovf_d;
      disp_en_q  <= disp_en_d;
      disp_val_q <= disp_val_d;
      shadow_q   <= shadow_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_calc_io_responder.sv
module tb_calc_io_responder;

  localparam logic [31:0] Base    = 32'h0000_0400;
  localparam int unsigned ScanDiv = 16;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] an;
  logic [6:0] seg;

  calc_io_responder_if bus_if ();

  calc_io_responder #(
    .IO_BASE    (Base),
    .FIFO_DEPTH (8),
    .SCAN_DIV   (ScanDiv)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus_if),
    .key_valid (key_valid),
    .key_code  (key_code),
    .an        (an),
    .seg       (seg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        kv;
    logic [3:0]  key;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Active-low {g..a} patterns for hex 0..F
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic kv, input logic [3:0] key, input logic re, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic s,
                     input logic [31:0] rd);
    vec_t v;
    v.kv = kv; v.key = key; v.re = re; v.we = we; v.addr = addr; v.wd = wd;
    v.exp_sel = s; v.exp_rd = rd;
    vq.push_back(v);
  endtask

  task automatic idle();
    key_valid = 1'b0; key_code = 4'h0;
    bus_if.RE = 1'b0; bus_if.WE = 1'b0; bus_if.A = 32'h0; bus_if.WD = 32'h0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    bus_if.A = addr; bus_if.WD = data; bus_if.WE = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_if.A = addr;
    #1;
    check(name, {bus_if.sel, bus_if.RD}, {1'b1, exp});
    tick();
    idle();
  endtask

  // Load value, enable display, then follow the scan for four full digit periods
  task automatic scan_check(input string name, input logic [15:0] value);
    int prev_idx, run_len, d;
    bit started;
    logic [6:0] exp_seg;
    bus_wr(Base + 32'h8, {16'hDEAD, value});
    bus_wr(Base + 32'hC, 32'h1);
    repeat (ScanDiv + 2) tick();
    prev_idx = -1; run_len = 0; started = 1'b0;
    for (int c = 0; c < 4 * ScanDiv; c++) begin
      case (an)
        4'hE:    d = 0;
        4'hD:    d = 1;
        4'hB:    d = 2;
        4'h7:    d = 3;
        default: d = -1;
      endcase
      check($sformatf("%s an one-hot-low", name), {63'h0, d >= 0}, 64'h1);
      if (d >= 0) begin
        exp_seg = seg_tab[value[4*d +: 4]];
        if (Lzb && d != 0 && (value >> (4 * d)) == 16'h0) exp_seg = 7'h7F;
        check($sformatf("%s seg digit%0d", name, d), {57'h0, seg}, {57'h0, exp_seg});
        if (prev_idx >= 0 && d != prev_idx) begin
          check($sformatf("%s digit order", name), d, (prev_idx + 1) % 4);
          if (started) check($sformatf("%s slot length", name), run_len, ScanDiv);
          started = 1'b1;
          run_len = 0;
        end
        run_len++;
        prev_idx = d;
      end
      tick();
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    repeat (3) tick();
    check("reset an", {60'h0, an}, 64'hF);
    check("reset seg", {57'h0, seg}, 64'h7F);
    RST = 1'b0;

    // Test 1/2: status after reset, then push three keys and drain them
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h0);
    add(1, 4'h3, 0, 0, 32'h0, 0, 0, 32'h0);
    add(1, 4'h7, 0, 0, 32'h0, 0, 0, 32'h0);
    add(1, 4'hA, 0, 0, 32'h0, 0, 0, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h31);
    add(0, 4'h0, 1, 0, Base, 0, 1, 32'h3);
    add(0, 4'h0, 1, 0, Base, 0, 1, 32'h7);
    add(0, 4'h0, 1, 0, Base, 0, 1, 32'hA);
    add(0, 4'h0, 1, 0, Base, 0, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h0);
    // Test 3: nine pushes (RE held outside the window must not pop), ninth dropped
    for (int k = 1; k <= 9; k++) add(1, 4'(k), 1, 0, Base + 32'h10, 0, 0, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h87);
    add(0, 4'h0, 1, 0, Base + 32'h7, 0, 1, 32'h87);
    add(0, 4'h0, 0, 1, Base + 32'hC, 32'h2, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h83);
    add(1, 4'hC, 1, 0, Base, 0, 1, 32'h1);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h83);
    add(1, 4'hD, 0, 1, Base + 32'hC, 32'h2, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h87);
    for (int k = 2; k <= 8; k++) add(0, 4'h0, 1, 0, Base, 0, 1, 32'(k));
    add(0, 4'h0, 1, 0, Base, 0, 1, 32'hC);
    add(0, 4'h0, 1, 0, Base, 0, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h4);
    add(0, 4'h0, 0, 1, Base + 32'hC, 32'h2, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h0);
    add(0, 4'h0, 0, 1, Base + 32'h4, 32'hFF, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h4, 0, 1, 32'h0);
    add(0, 4'h0, 0, 1, Base + 32'h8, 32'hFFFF_12AB, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'h8, 0, 1, 32'h12AB);
    add(0, 4'h0, 0, 1, Base + 32'hC, 32'h1, 1, 32'h0);
    add(0, 4'h0, 1, 0, Base + 32'hC, 0, 1, 32'h1);
    add(0, 4'h0, 0, 1, Base + 32'hC, 32'h0, 1, 32'h1);
    add(0, 4'h0, 1, 0, Base - 32'h4, 0, 0, 32'h0);

    foreach (vq[i]) begin
      key_valid = vq[i].kv; key_code = vq[i].key;
      bus_if.RE = vq[i].re; bus_if.WE = vq[i].we;
      bus_if.A = vq[i].addr; bus_if.WD = vq[i].wd;
      #1;
      check($sformatf("vec%0d sel/RD", i), {31'h0, bus_if.sel, bus_if.RD},
            {31'h0, vq[i].exp_sel, vq[i].exp_rd});
      tick();
    end
    idle();

    // Test 4: 0x12AB scanned, then display off
    scan_check("val12AB", 16'h12AB);
    bus_wr(Base + 32'hC, 32'h0);
    tick();
    check("off an", {60'h0, an}, 64'hF);
    check("off seg", {57'h0, seg}, 64'h7F);

    // Test 5: leading-zero behaviour
    scan_check("val0005", 16'h0005);
    scan_check("val0000", 16'h0000);

    // Test 6: reset mid-scan with a simultaneous key push and pop
    scan_check("val12AB again", 16'h12AB);
    key_valid = 1'b1; key_code = 4'h4; tick();
    key_valid = 1'b1; key_code = 4'h6; tick();
    idle();
    repeat (5) tick();
    RST = 1'b1; key_valid = 1'b1; key_code = 4'h5;
    bus_if.RE = 1'b1; bus_if.A = Base;
    tick();
    RST = 1'b0;
    idle();
    check("rst an", {60'h0, an}, 64'hF);
    check("rst seg", {57'h0, seg}, 64'h7F);
    rd_check("rst status", Base + 32'h4, 32'h0);
    rd_check("rst keydata", Base, 32'h0);
    rd_check("rst dispval", Base + 32'h8, 32'h0);
    rd_check("rst ctrl", Base + 32'hC, 32'h0);
    repeat (ScanDiv) tick();
    check("post-rst an", {60'h0, an}, 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
